// File: rtl/wch_scheduler_pkg.sv
// Shared types, width helper and default sizing for the STDP
// weight-change scheduler.
package snn_wch_pkg;

    localparam int WCH_M   = 784;
    localparam int WCH_N   = 16;
    localparam int WCH_W   = 24;
    localparam int WCH_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        SWEEP,
        DRAIN
    } wch_state_e;

    function automatic int wbits(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/wch_scheduler_if.sv
// Request/ack, LUT return and weight-write bundle of the scheduler.
// slave = scheduler side, master = surrounding neuron/LUT/RAM side.
interface wch_scheduler_if #(
    parameter int M = snn_wch_pkg::WCH_M,
    parameter int N = snn_wch_pkg::WCH_N,
    parameter int W = snn_wch_pkg::WCH_W
);
    import snn_wch_pkg::*;

    localparam int IW = wbits(M);
    localparam int NW = wbits(N);

    logic [N-1:0]  wch_req;
    logic [N-1:0]  wch_plus;
    logic [W-1:0]  del_w_plus;
    logic [W-1:0]  del_w_minus;
    logic [IW-1:0] ip_select;
    logic          busy;
    logic [N-1:0]  wch_ack;
    logic          wr_en;
    logic [NW-1:0] wr_neuron;
    logic [IW-1:0] wr_addr;
    logic [W-1:0]  wr_delta;
    logic          wr_plus;
    logic          done;

    modport slave (
        input  wch_req, wch_plus, del_w_plus, del_w_minus,
        output ip_select, busy, wch_ack,
        output wr_en, wr_neuron, wr_addr, wr_delta, wr_plus, done
    );

    modport master (
        output wch_req, wch_plus, del_w_plus, del_w_minus,
        input  ip_select, busy, wch_ack,
        input  wr_en, wr_neuron, wr_addr, wr_delta, wr_plus, done
    );

endinterface

// File: rtl/wch_scheduler_rr_arbiter.sv
// N-way round-robin arbiter: the first request at or after ptr wins,
// wrapping from N-1 back to 0.
module rr_arbiter
    import snn_wch_pkg::*;
#(
    parameter  int N  = WCH_N,
    localparam int NW = wbits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [NW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [NW-1:0] idx
);

    // Scan from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = NW'(j);
            end
        end
    end

endmodule

// File: rtl/wch_scheduler.sv
// STDP weight-change scheduler: round-robin grant, 0..M-1 sweep, LAT-deep
// write realignment. Define WCH_SKIP_ZERO_EN to suppress zero-delta writes.
module wch_scheduler
    import snn_wch_pkg::*;
#(
    parameter int M   = WCH_M,
    parameter int N   = WCH_N,
    parameter int W   = WCH_W,
    parameter int LAT = WCH_LAT
) (
    input  logic           clk,
    input  logic           rst,
    wch_scheduler_if.slave bus
);

    localparam int IW = wbits(M);
    localparam int NW = wbits(N);
    localparam int DW = wbits(LAT);
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);
    localparam logic [DW-1:0] LAST_DRN = DW'(LAT - 1);

    wch_state_e     state;
    wch_state_e     state_nx;
    logic [N-1:0]   pending;
    logic [N-1:0]   gnt;
    logic [N-1:0]   gnt_clr;
    logic [NW-1:0]  ptr;
    logic [NW-1:0]  gidx;
    logic [NW-1:0]  neu_q;
    logic           plus_q;
    logic [IW-1:0]  cnt;
    logic [DW-1:0]  dcnt;
    logic           arb;
    logic           sweep;
    logic           drain;
    logic           last;
    logic [LAT-1:0] pv;
    logic [IW-1:0]  pidx [LAT];
    logic           vt;
    logic [IW-1:0]  it;
    logic [W-1:0]   sel;

    rr_arbiter #(.N(N)) u_arb (
        .req   (pending),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gidx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (|pending) state_nx = ARB;
            ARB:     state_nx = SWEEP;
            SWEEP:   if (cnt == LAST_IDX) state_nx = DRAIN;
            DRAIN:   if (dcnt == LAST_DRN) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        arb   = 1'b0;
        sweep = 1'b0;
        drain = 1'b0;
        unique case (state)
            ARB:     arb   = 1'b1;
            SWEEP:   sweep = 1'b1;
            DRAIN:   drain = 1'b1;
            default: ;
        endcase
    end

    assign last          = sweep && (cnt == LAST_IDX);
    assign gnt_clr       = arb ? gnt : '0;
    assign bus.wch_ack   = gnt_clr;
    assign bus.busy      = arb | sweep | drain;
    assign bus.ip_select = cnt;

    // A request landing in its own grant cycle survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            ptr     <= '0;
            neu_q   <= '0;
            plus_q  <= 1'b0;
            cnt     <= '0;
            dcnt    <= '0;
        end else begin
            pending <= (pending & ~gnt_clr) | bus.wch_req;
            if (arb) begin
                ptr    <= (int'(gidx) == N - 1) ? '0 : gidx + NW'(1);
                neu_q  <= gidx;
                plus_q <= bus.wch_plus[gidx];
            end
            if (sweep) cnt <= last ? '0 : cnt + IW'(1);
            if (drain) dcnt <= (dcnt == LAST_DRN) ? '0 : dcnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < LAT; i++) pidx[i] <= '0;
        end else begin
            pv[0]   <= sweep;
            pidx[0] <= cnt;
            for (int i = 1; i < LAT; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
        end
    end

    assign vt  = pv[LAT-1];
    assign it  = pidx[LAT-1];
    assign sel = plus_q ? bus.del_w_plus : bus.del_w_minus;

`ifdef WCH_SKIP_ZERO_EN
    assign bus.wr_en = vt && (sel != '0);
`else
    assign bus.wr_en = vt;
`endif

    assign bus.wr_addr   = vt ? it : '0;
    assign bus.wr_neuron = vt ? neu_q : '0;
    assign bus.wr_plus   = vt & plus_q;
    assign bus.wr_delta  = vt ? sel : '0;
    assign bus.done      = vt && (it == LAST_IDX);

endmodule

// File: tb/tb_wch_scheduler.sv
// Randomized scoreboard bench for wch_scheduler (M=8, N=4, W=24, LAT=2).
// The count-mux/LUT path is emulated as two registers on ip_select.
module tb_wch_scheduler;

    localparam int M   = 8;
    localparam int N   = 4;
    localparam int W   = 24;
    localparam int LAT = 2;

`ifdef WCH_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        bit           en;
        int           neu;
        int           addr;
        bit           plus;
        logic [W-1:0] d;
        bit           done;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wch_scheduler_if #(.M(M), .N(N), .W(W)) bus ();

    wch_scheduler #(.M(M), .N(N), .W(W), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] ptab [M];
    logic [W-1:0] mtab [M];
    logic [2:0]   s1 = '0;
    logic [2:0]   s2 = '0;

    always @(posedge clk) begin
        s1 <= bus.ip_select;
        s2 <= s1;
    end

    assign bus.del_w_plus  = ptab[s2];
    assign bus.del_w_minus = mtab[s2];

    wr_t        expq[$];
    int         glog[$];
    bit [N-1:0] pend_m = '0;
    int         ptr_m = 0;
    int         exp_ip = -1;
    bit         chk_idle = 1'b0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int glog_code();
        int c = 0;
        foreach (glog[i]) c = c * 10 + glog[i] + 1;
        return c;
    endfunction

    // Predictor: on each grant, pick from the model and queue M writes.
    always @(negedge clk) begin
        int           g;
        bit           pl;
        logic [W-1:0] d;
        bit           en;
        wr_t          e;
        if (rst) begin
            exp_ip = -1;
        end else if (bus.wch_ack != '0) begin
            for (int k = 0; k < N; k++)
                if (bus.wch_ack[k]) glog.push_back(k);
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && pend_m[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            check("grant", bus.wch_ack, (g < 0) ? 0 : (64'd1 << g));
            if (g >= 0) begin
                pend_m[g] = 1'b0;
                ptr_m = (g + 1) % N;
                pl = bus.wch_plus[g];
                for (int a = 0; a < M; a++) begin
                    d  = pl ? ptab[a] : mtab[a];
                    en = SKIP ? (d != '0) : 1'b1;
                    if (en || a == M - 1) begin
                        e.en = en; e.neu = g; e.addr = a;
                        e.plus = pl; e.d = d; e.done = (a == M - 1);
                        expq.push_back(e);
                    end
                end
            end
            exp_ip = 0;
        end else if (exp_ip >= 0) begin
            check("ip_select", bus.ip_select, exp_ip);
            check("busy_sweep", bus.busy, 1);
            exp_ip++;
            if (exp_ip == M) exp_ip = -1;
        end
    end

    // Write monitor: pops the scoreboard whenever a write slot appears.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            expq.delete();
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("busy_after_done", bus.busy, 0);
                chk_idle = 1'b0;
            end
            if (bus.wr_en) wr_cnt++;
            if (bus.done) done_cnt++;
            if (bus.wr_en || bus.done) begin
                if (expq.size() == 0) begin
                    check("unexpected_write", {bus.wr_en, bus.done}, 0);
                end else begin
                    e = expq.pop_front();
                    check("write",
                          {bus.wr_en, bus.wr_neuron, bus.wr_addr,
                           bus.wr_plus, bus.wr_delta, bus.done},
                          {e.en, 2'(e.neu), 3'(e.addr), e.plus, e.d, e.done});
                    check("busy_in_write", bus.busy, 1);
                    if (bus.done) chk_idle = 1'b1;
                end
            end
        end
    end

    task automatic check_zero_outputs(input string name);
        check(name, {bus.ip_select, bus.busy, bus.wch_ack, bus.wr_en,
                     bus.wr_neuron, bus.wr_addr, bus.wr_delta,
                     bus.wr_plus, bus.done}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend_m = '0;
        ptr_m = 0;
        @(negedge clk);
        check_zero_outputs("rst_outputs");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_req(input logic [N-1:0] v);
        int t = 0;
        @(negedge clk);
        while (bus.wch_ack != '0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        bus.wch_req = v;
        pend_m |= v;
        @(negedge clk);
        bus.wch_req = '0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((bus.busy || pend_m != '0 || expq.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", t < 500, 1);
        @(negedge clk);
    endtask

    task automatic wait_ip(input int v);
        int t = 0;
        while (!(bus.busy && exp_ip > 0 && int'(bus.ip_select) == v) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("wait_ip_timeout", t < 200, 1);
    endtask

    function automatic logic [W-1:0] rnd_delta(input bit allow_zero);
        if (allow_zero && $urandom_range(0, 3) == 0) return '0;
        return W'($urandom_range(1, 32'hFF_FFFF));
    endfunction

    initial begin
        int wc;
        bus.wch_req  = '0;
        bus.wch_plus = '0;
        for (int a = 0; a < M; a++) begin
            ptab[a] = rnd_delta(1'b0);
            mtab[a] = rnd_delta(1'b0);
        end
        @(negedge clk);
        do_reset();

        // single request, potentiate
        glog.delete();
        wc = wr_cnt;
        bus.wch_plus = 4'b0100;
        pulse_req(4'b0100);
        wait_idle();
        check("single_order", glog_code(), 3);
        check("single_writes", wr_cnt - wc, 8);

        // contention from pointer 0
        do_reset();
        glog.delete();
        wc = wr_cnt;
        bus.wch_plus = 4'($urandom);
        pulse_req(4'b1011);
        wait_idle();
        check("contention_order", glog_code(), 124);
        check("contention_writes", wr_cnt - wc, 24);

        // re-request during own sweep
        glog.delete();
        wc = wr_cnt;
        pulse_req(4'b0010);
        wait_ip(3);
        pulse_req(4'b0010);
        wait_idle();
        check("rereq_order", glog_code(), 22);
        check("rereq_writes", wr_cnt - wc, 16);

        // depress path
        for (int a = 0; a < M; a++) mtab[a] = 24'h000005;
        bus.wch_plus = 4'b1110;
        pulse_req(4'b0001);
        wait_idle();

        // reset mid-sweep leaves pointer at 0 and stops writes
        bus.wch_plus = 4'b0100;
        pulse_req(4'b0100);
        wait_ip(4);
        rst = 1'b1;
        pend_m = '0;
        ptr_m = 0;
        @(negedge clk);
        check_zero_outputs("midsweep_rst_outputs");
        rst = 1'b0;
        wc = wr_cnt;
        repeat (6) @(negedge clk);
        check("no_wr_after_rst", wr_cnt - wc, 0);
        check_zero_outputs("idle_after_rst");
        glog.delete();
        pulse_req(4'b1001);
        wait_idle();
        check("ptr_after_rst", glog_code(), 14);

        // zero deltas at addresses 2 and 5
        for (int a = 0; a < M; a++) ptab[a] = rnd_delta(1'b0);
        ptab[2] = '0;
        ptab[5] = '0;
        bus.wch_plus = 4'b0001;
        wc = wr_cnt;
        done_cnt = 0;
        pulse_req(4'b0001);
        wait_idle();
        check("zero_delta_writes", wr_cnt - wc, SKIP ? 6 : 8);
        check("zero_delta_done", done_cnt, 1);

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            if (!bus.busy && pend_m == '0 && expq.size() == 0) begin
                for (int a = 0; a < M; a++) begin
                    ptab[a] = rnd_delta(1'b1);
                    mtab[a] = rnd_delta(1'b1);
                end
                bus.wch_plus = 4'($urandom);
            end
            pulse_req(4'($urandom_range(1, 15)));
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle();
        check("scoreboard_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
